// File: rtl/memshare_alloc_sched_if.sv
// Request/allocation bus of the shared message-memory allocation scheduler.
// The scheduler takes the slave side; whoever feeds requests takes the master side.
interface memshare_alloc_sched_if #(
    parameter int RQST_W      = 8,
    parameter int QUEUE_DEPTH = 4
);
    logic                         rqst_valid_i;
    logic                         rqst_ready_o;
    logic [RQST_W-1:0]            rqst_shift_i;
    logic                         alloc_valid_o;
    logic [RQST_W-1:0]            alloc_shift_o;
    logic                         alloc_seq_o;
    logic                         alloc_last_o;
    logic                         isGtr_o;
    logic                         pipeCycle_begin_o;
    logic [$clog2(QUEUE_DEPTH):0] occupancy_o;
    logic [7:0]                   bubble_cnt_o;

    modport slave (
        input  rqst_valid_i, rqst_shift_i,
        output rqst_ready_o, alloc_valid_o, alloc_shift_o, alloc_seq_o, alloc_last_o,
               isGtr_o, pipeCycle_begin_o, occupancy_o, bubble_cnt_o
    );

    modport master (
        output rqst_valid_i, rqst_shift_i,
        input  rqst_ready_o, alloc_valid_o, alloc_shift_o, alloc_seq_o, alloc_last_o,
               isGtr_o, pipeCycle_begin_o, occupancy_o, bubble_cnt_o
    );
endinterface

// File: rtl/memshare_alloc_sched.sv
// Allocation-sequence scheduler for the layered LDPC shared message memory: queues shift
// requests and issues one or two allocation sequences each, aligned to the pipeline-cycle phase.
module memshare_alloc_sched #(
    parameter int RQST_W      = 8,
    parameter int SPLIT_THR   = 64,
    parameter int QUEUE_DEPTH = 4,
    parameter int PIPE_LEN    = 4
) (
    input  logic                  sys_clk,
    input  logic                  rstn,
    memshare_alloc_sched_if.slave bus
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(PIPE_LEN);
    localparam logic [RQST_W-1:0] THR     = RQST_W'(SPLIT_THR);
    localparam logic [RQST_W-1:0] THR_M1  = RQST_W'(SPLIT_THR - 1);
    localparam logic [PW-1:0]     PH_LAST = PW'(PIPE_LEN - 1);
    localparam logic [CW-1:0]     DEPTH   = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_BUBBLE, S_SHIFT_GEN, S_SEQ2} state_t;

    logic [RQST_W-1:0] mem_r [QUEUE_DEPTH];
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [PW-1:0]     phase_r, nph_s;
    logic [RQST_W-1:0] work_shift_r, head_s;
    logic              work_gtr_r, head_gtr_s;
    logic [7:0]        bubble_cnt_r;
    state_t            state_r, state_d;
    logic              push_s, pop_s, done_s, ready_s;
    logic              alloc_valid_s, alloc_seq_s, alloc_last_s, is_gtr_s;
    logic [RQST_W-1:0] alloc_shift_s;

    assign head_s     = mem_r[rd_ptr_r];
    assign head_gtr_s = (head_s >= THR);
    assign nph_s      = (phase_r == PH_LAST) ? '0 : phase_r + PW'(1);
    // Readiness looks only at the registered count, so a pop never unblocks a full queue early.
    assign ready_s    = (count_r < DEPTH);
    assign push_s     = bus.rqst_valid_i && ready_s;

    assign bus.rqst_ready_o      = ready_s;
    assign bus.alloc_valid_o     = alloc_valid_s;
    assign bus.alloc_shift_o     = alloc_shift_s;
    assign bus.alloc_seq_o       = alloc_seq_s;
    assign bus.alloc_last_o      = alloc_last_s;
    assign bus.isGtr_o           = is_gtr_s;
    assign bus.pipeCycle_begin_o = (phase_r == '0);
    assign bus.occupancy_o       = count_r;
    assign bus.bubble_cnt_o      = bubble_cnt_r;

    // Request storage; no reset needed because the pointers define validity.
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.rqst_shift_i;
        end
    end

    // Queue pointers, occupancy, phase, working request and bubble counter.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            phase_r      <= '0;
            work_shift_r <= '0;
            work_gtr_r   <= 1'b0;
            bubble_cnt_r <= 8'd0;
        end else begin
            phase_r <= nph_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r     <= rd_ptr_r + AW'(1);
                work_shift_r <= head_s;
                work_gtr_r   <= head_gtr_s;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CW'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CW'(1);
            end
            if ((state_d == S_BUBBLE) && (bubble_cnt_r != 8'hFF)) begin
                bubble_cnt_r <= bubble_cnt_r + 8'd1;
            end
        end
    end

    // Scheduler state register.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_d;
        end
    end

    // Next-state, pop decision and Moore output decode.
    always_comb begin
        state_d       = state_r;
        pop_s         = 1'b0;
        done_s        = 1'b0;
        alloc_valid_s = 1'b0;
        alloc_shift_s = '0;
        alloc_seq_s   = 1'b0;
        alloc_last_s  = 1'b0;
        is_gtr_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                done_s = 1'b1;
            end
            S_BUBBLE: begin
                pop_s   = 1'b1;
                state_d = S_SHIFT_GEN;
            end
            S_SHIFT_GEN: begin
                alloc_valid_s = 1'b1;
                alloc_shift_s = work_gtr_r ? THR_M1 : work_shift_r;
                alloc_last_s  = ~work_gtr_r;
                is_gtr_s      = work_gtr_r;
                if (work_gtr_r) begin
                    state_d = S_SEQ2;
                end else begin
                    done_s = 1'b1;
                end
            end
            S_SEQ2: begin
                alloc_valid_s = 1'b1;
                alloc_shift_s = work_shift_r - THR;
                alloc_seq_s   = 1'b1;
                alloc_last_s  = 1'b1;
                done_s        = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A split request may only start where its second sequence still lands before phase 0.
        if (done_s) begin
            if (count_r == '0) begin
                state_d = S_IDLE;
            end else if (head_gtr_s && (nph_s == PH_LAST)) begin
                state_d = S_BUBBLE;
            end else begin
                pop_s   = 1'b1;
                state_d = S_SHIFT_GEN;
            end
        end else begin
            pop_s = pop_s;
        end
    end
endmodule

// File: tb/tb_memshare_alloc_sched.sv
// Bench for memshare_alloc_sched: directed scenarios plus random traffic, each cycle
// compared against a queue-level model of the request stream and its expanded sequences.
module tb_memshare_alloc_sched;
    localparam int RW  = 8;
    localparam int THR = 64;
    localparam int QD  = 4;
    localparam int PL  = 4;

    typedef struct packed {
        logic [7:0] sh;
        logic       seq;
        logic       last;
        logic       gtr;
    } ent_t;

    logic sys_clk = 1'b0;
    logic rstn    = 1'b0;
    always #5 sys_clk = ~sys_clk;

    memshare_alloc_sched_if #(.RQST_W(RW), .QUEUE_DEPTH(QD)) bus ();

    memshare_alloc_sched #(.RQST_W(RW), .SPLIT_THR(THR), .QUEUE_DEPTH(QD), .PIPE_LEN(PL)) dut (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .bus     (bus)
    );

    int         checks = 0;
    int         passes = 0;
    int         fails  = 0;
    logic [7:0] mq[$];
    ent_t       cur[$];
    int         mphase = 0;
    int         mbcnt  = 0;
    bit         mbub   = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp5 [6] = '{8'd5, 8'd63, 8'd16, 8'd12, 8'd63, 8'd136};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic expand(input logic [7:0] s);
        if (s >= 8'(THR)) begin
            cur.push_back('{sh: 8'(THR - 1), seq: 1'b0, last: 1'b0, gtr: 1'b1});
            cur.push_back('{sh: s - 8'(THR), seq: 1'b1, last: 1'b1, gtr: 1'b0});
        end else begin
            cur.push_back('{sh: s, seq: 1'b0, last: 1'b1, gtr: 1'b0});
        end
    endtask

    task automatic model_edge(input logic v, input logic [7:0] s, input logic r);
        bit was_bub;
        bit rdy;
        int nph;
        if (!r) begin
            mq.delete();
            cur.delete();
            mbub   = 0;
            mbcnt  = 0;
            mphase = 0;
        end else begin
            rdy     = (mq.size() < QD);
            nph     = (mphase + 1) % PL;
            was_bub = mbub;
            mbub    = 0;
            if (cur.size() > 0) void'(cur.pop_front());
            if (was_bub) begin
                expand(mq.pop_front());
            end else if (cur.size() == 0 && mq.size() > 0) begin
                if (mq[0] >= 8'(THR) && nph == PL - 1) begin
                    mbub = 1;
                    if (mbcnt < 255) mbcnt++;
                end else begin
                    expand(mq.pop_front());
                end
            end
            if (v && rdy) mq.push_back(s);
            mphase = nph;
        end
    endtask

    task automatic compare_all();
        ent_t e;
        e = '0;
        if (cur.size() > 0) e = cur[0];
        chk("alloc_valid", 32'(bus.alloc_valid_o), 32'(cur.size() > 0));
        chk("alloc_shift", 32'(bus.alloc_shift_o), 32'(e.sh));
        chk("alloc_seq",   32'(bus.alloc_seq_o),   32'(e.seq));
        chk("alloc_last",  32'(bus.alloc_last_o),  32'(e.last));
        chk("isGtr",       32'(bus.isGtr_o),       32'(e.gtr));
        chk("pipe_begin",  32'(bus.pipeCycle_begin_o), 32'(mphase == 0));
        chk("occupancy",   32'(bus.occupancy_o),   32'(mq.size()));
        chk("ready",       32'(bus.rqst_ready_o),  32'(mq.size() < QD));
        chk("bubble_cnt",  32'(bus.bubble_cnt_o),  32'(mbcnt));
        if (bus.alloc_seq_o === 1'b1) chk("seq2_not_phase0", 32'(bus.pipeCycle_begin_o), 32'd0);
        if (bus.alloc_valid_o === 1'b1) got_q.push_back(bus.alloc_shift_o);
    endtask

    task automatic step(input logic v, input logic [7:0] s, input logic r);
        bus.rqst_valid_i = v;
        bus.rqst_shift_i = s;
        rstn             = r;
        @(posedge sys_clk);
        model_edge(v, s, r);
        @(negedge sys_clk);
        compare_all();
    endtask

    initial begin
        int  sent;
        int  mxocc;
        bit  saw_nrdy;
        bit  rdy;
        bit  found;
        int  b0;
        bus.rqst_valid_i = 1'b0;
        bus.rqst_shift_i = 8'd0;
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);

        // Single short request accepted with phase 0 at the edge.
        step(1'b1, 8'd10, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        chk("t1_valid", 32'(bus.alloc_valid_o), 32'd1);
        chk("t1_shift", 32'(bus.alloc_shift_o), 32'd10);
        chk("t1_last",  32'(bus.alloc_last_o), 32'd1);
        step(1'b0, 8'd0, 1'b1);
        chk("t1_idle", 32'(bus.alloc_valid_o), 32'd0);

        // Split request without alignment bubble.
        for (int i = 0; i < PL && mphase != 0; i++) step(1'b0, 8'd0, 1'b1);
        step(1'b1, 8'd100, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        chk("t2_sg_shift", 32'(bus.alloc_shift_o), 32'd63);
        chk("t2_sg_gtr",   32'(bus.isGtr_o), 32'd1);
        step(1'b0, 8'd0, 1'b1);
        chk("t2_s2_shift", 32'(bus.alloc_shift_o), 32'd36);
        chk("t2_s2_seq",   32'(bus.alloc_seq_o), 32'd1);
        step(1'b0, 8'd0, 1'b1);

        // Split request that must wait one bubble for phase 0.
        for (int i = 0; i < PL && mphase != 1; i++) step(1'b0, 8'd0, 1'b1);
        b0 = int'(bus.bubble_cnt_o);
        step(1'b1, 8'd100, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        chk("t3_bubble_valid", 32'(bus.alloc_valid_o), 32'd0);
        chk("t3_bubble_cnt",   32'(bus.bubble_cnt_o), 32'(b0 + 1));
        step(1'b0, 8'd0, 1'b1);
        chk("t3_sg_phase0", 32'(bus.pipeCycle_begin_o), 32'd1);
        chk("t3_sg_shift",  32'(bus.alloc_shift_o), 32'd63);
        step(1'b0, 8'd0, 1'b1);
        chk("t3_s2_shift", 32'(bus.alloc_shift_o), 32'd36);
        step(1'b0, 8'd0, 1'b1);

        // Eight split requests under backpressure.
        got_q.delete();
        sent = 0; mxocc = 0; saw_nrdy = 0;
        for (int i = 0; i < 80 && sent < 8; i++) begin
            rdy = bus.rqst_ready_o;
            step(1'b1, 8'd70, 1'b1);
            if (rdy) sent++;
            if (int'(bus.occupancy_o) > mxocc) mxocc = int'(bus.occupancy_o);
            if (bus.rqst_ready_o === 1'b0) saw_nrdy = 1;
        end
        for (int i = 0; i < 40; i++) step(1'b0, 8'd0, 1'b1);
        chk("t4_sent", 32'(sent), 32'd8);
        chk("t4_max_occ", 32'(mxocc), 32'd4);
        chk("t4_backpressure", 32'(saw_nrdy), 32'd1);
        chk("t4_seq_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < got_q.size(); i++)
            chk("t4_order", 32'(got_q[i]), (i % 2 == 0) ? 32'd63 : 32'd6);

        // Mixed stream.
        got_q.delete();
        step(1'b1, 8'd5, 1'b1);
        step(1'b1, 8'd80, 1'b1);
        step(1'b1, 8'd12, 1'b1);
        step(1'b1, 8'd200, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 8'd0, 1'b1);
        chk("t5_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) chk("t5_shift", 32'(got_q[i]), 32'(exp5[i]));

        // Reset while a second sequence is out and three requests are queued.
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.alloc_seq_o === 1'b1 && bus.occupancy_o == 3) begin
                found = 1;
                break;
            end
            step(bus.occupancy_o < 3, 8'd200, 1'b1);
        end
        chk("t6_reached_seq2", 32'(found), 32'd1);
        step(1'b0, 8'd0, 1'b0);
        chk("t6_valid", 32'(bus.alloc_valid_o), 32'd0);
        chk("t6_occ",   32'(bus.occupancy_o), 32'd0);
        chk("t6_ready", 32'(bus.rqst_ready_o), 32'd1);
        chk("t6_begin", 32'(bus.pipeCycle_begin_o), 32'd1);
        got_q.delete();
        for (int i = 0; i < 10; i++) step(1'b0, 8'd0, 1'b1);
        chk("t6_no_issue", 32'(got_q.size()), 32'd0);

        // Random traffic with shifts biased around the split threshold.
        for (int i = 0; i < 500; i++) begin
            logic       v;
            logic [7:0] s;
            v = ($urandom_range(0, 2) != 0);
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(60, 70)) : 8'($urandom_range(0, 255));
            step(v, s, ($urandom_range(0, 99) != 0));
        end
        for (int i = 0; i < 20; i++) step(1'b0, 8'd0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/memshare_alloc_sched.md
Name: memshare_alloc_sched

Overview:
- Allocation-sequence scheduler for the shared message memory in the layered LDPC decoder.
- Buffers incoming shift requests and decides per request whether one or two allocation sequences are needed (isGtr).
- Issues the sequences one per cycle to the shared memory port, aligned to a free-running pipeline-cycle phase.
- Drives the isGtr and pipeline-begin status consumed by the memShare monitoring logic.

Parameters:
- RQST_W, 8: width of request shift value.
- SPLIT_THR, 64: shift threshold; shift >= SPLIT_THR needs two sequences. Must be < 2^RQST_W.
- QUEUE_DEPTH, 4: request FIFO depth, power of 2, >= 2.
- PIPE_LEN, 4: cycles per memShare pipeline cycle, >= 2.

Ports:
- sys_clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- rqst_valid_i  in  1  request present
- rqst_ready_o  out  1  FIFO can accept
- rqst_shift_i  in  RQST_W  request shift value
- alloc_valid_o  out  1  allocation sequence issued this cycle
- alloc_shift_o  out  RQST_W  shift for the issued sequence
- alloc_seq_o  out  1  0 = first sequence, 1 = second sequence
- alloc_last_o  out  1  final sequence of the current request
- isGtr_o  out  1  current SHIFT_GEN request needs two sequences
- pipeCycle_begin_o  out  1  phase == 0
- occupancy_o  out  $clog2(QUEUE_DEPTH)+1  FIFO entry count
- bubble_cnt_o  out  8  saturating count of alignment bubbles

Behaviour:
- Reset: rstn is synchronous, active-low; clock sys_clk. Reset clears the FIFO, sets phase to 0 and the FSM to IDLE, and zeroes all outputs except rqst_ready_o=1 and pipeCycle_begin_o=1. A mid-operation reset drops queued and in-flight requests; no further alloc_valid_o appears until new requests arrive.
- Phase counter: phase_q runs 0..PIPE_LEN-1 and wraps every cycle. pipeCycle_begin_o = (phase_q == 0).
- FIFO push and backpressure:
  - Push on valid && ready at a clock edge.
  - rqst_ready_o = (count < QUEUE_DEPTH), combinational from registered count.
  - When full, ready = 0 even if a pop occurs that cycle.
  - Simultaneous push and pop (not full) leaves count unchanged.
- gtr = (head shift >= SPLIT_THR), computed at pop time and stored with the working request.
- FSM states: IDLE, BUBBLE, SHIFT_GEN, SEQ2. Decisions are made at the clock edge, using head-of-FIFO and nph = (phase_q+1) mod PIPE_LEN.
  - From IDLE, SHIFT_GEN, or SEQ2, when the current request has completed and the FIFO is non-empty:
    - If head gtr and nph == PIPE_LEN-1: go to BUBBLE, no pop.
    - Otherwise: pop the head into the working register and go to SHIFT_GEN.
  - Completion rules:
    - SHIFT_GEN with gtr=0 is complete.
    - SHIFT_GEN with gtr=1 always goes to SEQ2 next.
    - SEQ2 is complete.
  - FIFO empty at a completion point: go to IDLE.
  - BUBBLE: next cycle is phase 0, so pop and go to SHIFT_GEN unconditionally.
- Outputs (Moore, from state and working register):
  - SHIFT_GEN:
    - alloc_valid_o=1, alloc_seq_o=0.
    - alloc_shift_o = shift if gtr=0, SPLIT_THR-1 if gtr=1.
    - alloc_last_o = ~gtr, isGtr_o = gtr.
  - SEQ2: alloc_valid_o=1, alloc_seq_o=1, alloc_shift_o = shift - SPLIT_THR (no underflow possible), alloc_last_o=1, isGtr_o=0.
  - IDLE and BUBBLE: alloc_valid_o=0, and other alloc outputs are 0.
- Invariant: a two-sequence request never straddles a pipeline-cycle boundary, i.e. SEQ2 never occurs with phase_q == 0.
- bubble_cnt_o increments once per BUBBLE cycle and saturates at 255.
- Latency: with an empty FIFO, the FSM IDLE, and no bubble, a request accepted at edge E0 produces alloc_valid_o in the cycle after edge E1.
- Throughput: one sequence per cycle; back-to-back requests issue without gaps except alignment bubbles.

Test Plan:
1. Reset, then shift=10 accepted with phase_q=0 at the edge: alloc_valid_o=1 two cycles later with shift=10, seq=0, last=1, isGtr_o=0; then IDLE.
2. shift=100 (SPLIT_THR=64) accepted when nph != 3: SHIFT_GEN outputs 63, seq=0, isGtr_o=1; next cycle SEQ2 outputs 36, seq=1, last=1.
3. shift=100 becomes head when nph == 3: one BUBBLE cycle (alloc_valid_o=0, bubble_cnt_o 0->1), then SHIFT_GEN at phase 0 and SEQ2 at phase 1.
4. Hold valid for 8 requests of shift 70 with ready honored:
   - occupancy_o reaches 4 and rqst_ready_o deasserts.
   - All 16 sequences are issued in order.
   - SEQ2 never appears at phase 0.
5. Mixed stream 5, 80, 12, 200: issued shifts 5 / 63, 16 / 12 / 63, 136 with correct seq/last flags, plus bubbles only where required.
6. Assert rstn=0 during SEQ2 with 3 queued entries: the next cycle has all outputs at reset values, occupancy_o=0, and no further alloc_valid_o without new requests.
